// File: rtl/dcache_wb_sender_pkg.sv
// Shared constants and state encoding for the data-cache write-back sender.
package dcache_wb_sender_pkg;

  localparam int unsigned INDEX_WIDTH    = 7;
  localparam int unsigned TAG_WIDTH      = 20;
  localparam int unsigned WORDS_PER_LINE = 8;
  localparam int unsigned OFFSET_WIDTH   = 5;
  localparam int unsigned BEAT_WIDTH     = 3;

  typedef enum logic [2:0] {
    WB_IDLE,
    WB_READ,
    WB_CAPTURE,
    WB_ADDR,
    WB_DATA,
    WB_RESP
  } wb_state_t;

endpackage

// File: rtl/dcache_wb_sender_line_buf.sv
// Line capture register: holds one cache line and selects the word for the current beat.
module wb_line_buf
  import dcache_wb_sender_pkg::*;
#(
  parameter int unsigned WORDS = WORDS_PER_LINE
) (
  input  logic                  clk,
  input  logic                  load,
  input  logic [WORDS*32-1:0]   line_in,
  input  logic [BEAT_WIDTH-1:0] beat,
  output logic [31:0]           word
);

  logic [WORDS*32-1:0] line_q;

  // Capture the BRAM output once; contents stay frozen until the next load.
  always_ff @(posedge clk) begin
    if (load) begin
      line_q <= line_in;
    end
  end

  // Word select for the beat currently on the data channel.
  always_comb begin
    word = line_q[{beat, 5'b0} +: 32];
  end

endmodule

// File: rtl/dcache_wb_sender.sv
// Write-back engine: reads one set from the cache arrays and sends it to memory
// as a single 8-beat write burst (address, data, response channels).
module dcache_wb_sender
  import dcache_wb_sender_pkg::*;
#(
  parameter int unsigned WORDS     = WORDS_PER_LINE,
  parameter int unsigned BURST_LEN = WORDS - 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [INDEX_WIDTH-1:0] req_index,
  output logic [INDEX_WIDTH-1:0] rd_addr,
  input  logic [TAG_WIDTH-1:0]   rd_tag,
  input  logic                   rd_vl,
  input  logic [WORDS*32-1:0]    rd_data,
  output logic                   aw_valid,
  input  logic                   aw_ready,
  output logic [31:0]            aw_addr,
  output logic [7:0]             aw_len,
  output logic                   w_valid,
  input  logic                   w_ready,
  output logic [31:0]            w_data,
  output logic                   w_last,
  input  logic                   b_valid,
  output logic                   b_ready,
  output logic                   done,
  output logic                   done_skip
);

  localparam logic [BEAT_WIDTH-1:0] LAST_BEAT = BEAT_WIDTH'(WORDS - 1);

  wb_state_t             state;
  logic [TAG_WIDTH-1:0]  tag_q;
  logic [BEAT_WIDTH-1:0] beat;
  logic                  done_q;
  logic                  skip;
  logic [31:0]           buf_word;

  wb_line_buf #(
    .WORDS (WORDS)
  ) u_line_buf (
    .clk     (clk),
    .load    (state == WB_CAPTURE),
    .line_in (rd_data),
    .beat    (beat),
    .word    (buf_word)
  );

  // Sequencer: index capture, BRAM read, burst handshakes and completion pulse.
  // rd_addr doubles as the registered index so it holds its value outside READ.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= WB_IDLE;
      rd_addr  <= '0;
      tag_q    <= '0;
      beat     <= '0;
      aw_valid <= 1'b0;
      w_valid  <= 1'b0;
      b_ready  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        WB_IDLE: begin
          if (req_valid) begin
            rd_addr <= req_index;
            state   <= WB_READ;
          end
        end
        WB_READ: begin
          state <= WB_CAPTURE;
        end
        WB_CAPTURE: begin
          tag_q <= rd_tag;
          if (rd_vl) begin
            aw_valid <= 1'b1;
            state    <= WB_ADDR;
          end else begin
            state <= WB_IDLE;
          end
        end
        WB_ADDR: begin
          if (aw_ready) begin
            aw_valid <= 1'b0;
            w_valid  <= 1'b1;
            state    <= WB_DATA;
          end
        end
        WB_DATA: begin
          if (w_ready) begin
            beat <= beat + 1'b1;
            if (beat == LAST_BEAT) begin
              w_valid <= 1'b0;
              b_ready <= 1'b1;
              state   <= WB_RESP;
            end
          end
        end
        WB_RESP: begin
          if (b_valid) begin
            b_ready <= 1'b0;
            done_q  <= 1'b1;
            state   <= WB_IDLE;
          end
        end
        default: begin
          state <= WB_IDLE;
        end
      endcase
    end
  end

  // Output decode. The skip completion depends on the valid bit that only exists
  // during CAPTURE, so it is taken straight from rd_vl rather than registered.
  always_comb begin
    skip      = (state == WB_CAPTURE) && !rd_vl;
    done      = done_q | skip;
    done_skip = skip;
    req_ready = (state == WB_IDLE);
    aw_addr   = {tag_q, rd_addr, {OFFSET_WIDTH{1'b0}}};
    aw_len    = 8'(BURST_LEN);
    w_data    = w_valid ? buf_word : '0;
    w_last    = w_valid && (beat == LAST_BEAT);
  end

endmodule
